etap_tap_ctrl: RTL and testbench
================================

# etap_tap_ctrl

EJTAG TAP controller for the SchoolMIPS debug path. It runs the IEEE 1149.1 16-state TAP state machine from TMS and holds the 5-bit EJTAG instruction register. It decodes the instruction into the 4-bit data-register select, and generates the `shift_dr` / `clk_dr` / `update_dr` strobes. It sits directly upstream of `mux_dr`, which routes those strobes to the selected data register. It also takes the muxed serial data back from `mux_dr` to drive TDO.

## Interface
- `IR_W`, default 5: instruction register width (EJTAG).
- `tck` input, 1 bit: sole clock; all state changes on rising edge.
- `trst` input, 1 bit: reset, synchronous, active-high.
- `tms` input, 1 bit: TAP mode select, sampled on rising `tck`.
- `tdi` input, 1 bit: serial data in.
- `s_data_out` input, 1 bit: serial bit of the selected DR, from `mux_dr`.
- `tdo` output, 1 bit: serial data out.
- `tdo_oe` output, 1 bit: high in Shift-IR or Shift-DR.
- `shift_dr` output, 1 bit: high in Shift-DR.
- `clk_dr` output, 1 bit: DR clock enable, high in Capture-DR or Shift-DR.
- `update_dr` output, 1 bit: high for the single cycle spent in Update-DR.
- `sel` output, 4 bits: DR select for `mux_dr`.
- `ir` output, `IR_W` bits: current instruction.
- `tlr` output, 1 bit: high in Test-Logic-Reset.

## Operation
- **State register.** 4-bit, 16 states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- **Transitions.** Standard 1149.1 transitions on `tms`. Any state reaches TLR after at most 5 consecutive `tms`=1 cycles.
- **IR shift register (`ir_sh`).**
  - CAP_IR loads `5'b00001`.
  - SH_IR loads `{tdi, ir_sh[4:1]}`.
  - UPD_IR copies `ir_sh` to `ir`.
  - TLR forces `ir` = IDCODE (`5'h01`).
- **Opcode → `sel` decode** (combinational from `ir`):
  - `0x01` IDCODE→0
  - `0x03` IMPCODE→1
  - `0x08` ADDRESS→2
  - `0x09` DATA→3
  - `0x0A` CONTROL→4
  - `0x0C` EJTAGBOOT→5
  - `0x02` SAMPLE_PRELOAD→6
  - `0x1F` and every other opcode → BYPASS 7.
  - Bit 3 of `sel` is always 0.
- **Output decode.** Strobes are Moore outputs decoded from the current state only. `clk_dr`=1 with `shift_dr`=0 marks capture.
- **TDO.**
  - SH_IR: `tdo` = `ir_sh[0]`.
  - SH_DR: `tdo` = `s_data_out`.
  - Otherwise `tdo` = 0.
- **IR-path activity.** Nothing on the IR path asserts any DR strobe.

## Timing
- **Reset.** `trst`=1 at a rising edge gives state=TLR, `ir`=`5'h01`, `ir_sh`=`5'h01`. In the following cycle:
  - `sel`=0, `tlr`=1.
  - `shift_dr`=`clk_dr`=`update_dr`=`tdo`=`tdo_oe`=0.
- **Reset priority.** Reset mid-scan (any state) aborts the scan. `ir` is not updated from a partial `ir_sh`. `trst` overrides `tms`.
- **Strobe latency.** Strobes change one edge after the `tms` value that causes the state change.
- **`update_dr` width.** Exactly one `tck` cycle per UPD_DR visit.
- **`sel` change point.** `sel` changes in the cycle after the UPD_IR edge: the cycle in which the state is RTI or SEL_DR.
- **`sel` stability.** `sel` is stable through all DR states.
- **Shift count.** N cycles in SH_DR give N `shift_dr` cycles plus 1 capture cycle of `clk_dr`.
- **Pause.** PAU_DR / PAU_IR hold all strobes low and `ir_sh` unchanged.
- **TDO timing.** `tdo` is combinational from registered state and `ir_sh` / `s_data_out`. It is valid for the whole cycle in which the bit is shifted out.

## Structure
- **Shared package** `etap_constants.vh`: holds
  - the 16 state codes;
  - the IR opcodes (`ETAP_OP_*`);
  - the `SEL_*` indices already used by `mux_dr`;
  - the IR capture value `5'b00001`.
- **Sub-module `etap_ir_decode`:** combinational opcode → `sel`. It is shared with any future IR consumer.

## Test plan
- **Reset.** `trst`=1 for 1 cycle from SH_DR → next cycle `tlr`=1, `sel`=0, `ir`=`0x01`, all strobes 0.
- **Escape from Shift-DR.** From SH_DR, `tms`=1 for 5 cycles, no reset → TLR reached on the 5th edge, `ir`=`0x01`.
- **IR load DATA.** IR scan of `0x09` (LSB first: 1,0,0,1,0) → during SH_IR `tdo` shows 1,0,0,0,0. After UPD_IR, `ir`=`0x09`, `sel`=3.
- **Unknown opcode.** IR scan of `0x15` → `sel`=7. IR scan of `0x0C` → `sel`=5.
- **DR scan timing.** DR scan of 32 shifts with `s_data_out` driven by a pattern:
  - `clk_dr` high 33 cycles, `shift_dr` high 32 cycles;
  - `update_dr` high exactly 1 cycle;
  - `tdo` equals `s_data_out` in every SH_DR cycle, `tdo_oe`=1 only there.
- **Pause and aborted IR scan.** Scan with SH_DR→EX1_DR→PAU_DR (3 cycles)→EX2_DR→SH_DR → strobes low during pause, shift count is continuous. Reset asserted mid-IR-scan → `ir` is `0x01`, not the partial value.

Source files
------------

// File: rtl/etap_tap_ctrl_pkg.sv
// EJTAG TAP shared constants: state codes, IR opcodes, DR select indices.
// Latency: none (types, constants and a pure next-state function).
// Backpressure: not applicable.
package etap_tap_ctrl_pkg;

    // Codes follow the 1149.1 reference encoding so a scope trace reads like the standard.
    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_e;

    localparam logic [4:0] ETAP_OP_IDCODE         = 5'h01;
    localparam logic [4:0] ETAP_OP_SAMPLE_PRELOAD = 5'h02;
    localparam logic [4:0] ETAP_OP_IMPCODE        = 5'h03;
    localparam logic [4:0] ETAP_OP_ADDRESS        = 5'h08;
    localparam logic [4:0] ETAP_OP_DATA           = 5'h09;
    localparam logic [4:0] ETAP_OP_CONTROL        = 5'h0A;
    localparam logic [4:0] ETAP_OP_EJTAGBOOT      = 5'h0C;
    localparam logic [4:0] ETAP_OP_BYPASS         = 5'h1F;

    localparam logic [3:0] SEL_IDCODE         = 4'd0;
    localparam logic [3:0] SEL_IMPCODE        = 4'd1;
    localparam logic [3:0] SEL_ADDRESS        = 4'd2;
    localparam logic [3:0] SEL_DATA           = 4'd3;
    localparam logic [3:0] SEL_CONTROL        = 4'd4;
    localparam logic [3:0] SEL_EJTAGBOOT      = 4'd5;
    localparam logic [3:0] SEL_SAMPLE_PRELOAD = 4'd6;
    localparam logic [3:0] SEL_BYPASS         = 4'd7;

    localparam logic [4:0] ETAP_IR_CAPTURE = 5'b00001;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: n = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: n = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/etap_ir_decode.sv
// EJTAG instruction to data-register select decode.
// Latency: combinational.
// Backpressure: none.
module etap_ir_decode
    import etap_tap_ctrl_pkg::*;
#(
    parameter int IR_W = 5
) (
    input  logic [IR_W-1:0] ir_i,
    output logic [3:0]      sel_o
);

    always_comb begin
        sel_o = SEL_BYPASS;
        case (ir_i)
            IR_W'(ETAP_OP_IDCODE):         sel_o = SEL_IDCODE;
            IR_W'(ETAP_OP_IMPCODE):        sel_o = SEL_IMPCODE;
            IR_W'(ETAP_OP_ADDRESS):        sel_o = SEL_ADDRESS;
            IR_W'(ETAP_OP_DATA):           sel_o = SEL_DATA;
            IR_W'(ETAP_OP_CONTROL):        sel_o = SEL_CONTROL;
            IR_W'(ETAP_OP_EJTAGBOOT):      sel_o = SEL_EJTAGBOOT;
            IR_W'(ETAP_OP_SAMPLE_PRELOAD): sel_o = SEL_SAMPLE_PRELOAD;
            default:                       sel_o = SEL_BYPASS;
        endcase
    end

endmodule

// File: rtl/etap_tap_ctrl.sv
// EJTAG TAP controller: 1149.1 state machine, instruction register, DR strobes and TDO.
// Latency: strobes are Moore outputs, one tck edge after the causing tms; tdo is combinational.
// Backpressure: none; the debug host owns tck/tms pacing.
module etap_tap_ctrl
    import etap_tap_ctrl_pkg::*;
#(
    parameter int IR_W = 5
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tms,
    input  logic            tdi,
    input  logic            s_data_out,
    output logic            tdo,
    output logic            tdo_oe,
    output logic            shift_dr,
    output logic            clk_dr,
    output logic            update_dr,
    output logic [3:0]      sel,
    output logic [IR_W-1:0] ir,
    output logic            tlr
);

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sh_q, ir_sh_d;

    always_ff @(posedge tck) begin
        if (trst) begin
            state_q <= TAP_TLR;
            ir_q    <= IR_W'(ETAP_OP_IDCODE);
            ir_sh_q <= IR_W'(ETAP_IR_CAPTURE);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_sh_q <= ir_sh_d;
        end
    end

    always_comb begin
        state_d = tap_next(state_q, tms);
        ir_d    = ir_q;
        ir_sh_d = ir_sh_q;
        case (state_q)
            TAP_CAP_IR: ir_sh_d = IR_W'(ETAP_IR_CAPTURE);
            TAP_SH_IR:  ir_sh_d = {tdi, ir_sh_q[IR_W-1:1]};
            TAP_UPD_IR: ir_d    = ir_sh_q;
            default:    ;
        endcase
        // Forcing on entry means ir already reads IDCODE in the first TLR cycle.
        if (state_d == TAP_TLR) begin
            ir_d = IR_W'(ETAP_OP_IDCODE);
        end
    end

    always_comb begin
        shift_dr  = (state_q == TAP_SH_DR);
        clk_dr    = (state_q == TAP_SH_DR) || (state_q == TAP_CAP_DR);
        update_dr = (state_q == TAP_UPD_DR);
        tlr       = (state_q == TAP_TLR);
        tdo_oe    = (state_q == TAP_SH_DR) || (state_q == TAP_SH_IR);
        tdo       = 1'b0;
        case (state_q)
            TAP_SH_IR: tdo = ir_sh_q[0];
            TAP_SH_DR: tdo = s_data_out;
            default:   tdo = 1'b0;
        endcase
    end

    assign ir = ir_q;

    etap_ir_decode #(
        .IR_W (IR_W)
    ) u_ir_decode (
        .ir_i  (ir_q),
        .sel_o (sel)
    );

endmodule

// File: tb/tb_etap_tap_ctrl.sv
// Bench for etap_tap_ctrl: directed TAP scenarios plus random tms/tdi/trst against a table-driven model.
// Latency: outputs sampled 1 time unit after each rising tck.
// Backpressure: not applicable.
module tb_etap_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       sdo = 1'b0;
    logic       tdo, tdo_oe, shift_dr, clk_dr, update_dr, tlr;
    logic [3:0] sel;
    logic [4:0] ir;

    int n_checks = 0;
    int n_pass   = 0;

    etap_tap_ctrl #(.IR_W(5)) dut (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tdi        (tdi),
        .s_data_out (sdo),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .sel        (sel),
        .ir         (ir),
        .tlr        (tlr)
    );

    always #5 tck = ~tck;

    // Model states numbered in the order the TAP diagram lists them.
    localparam int S_TLR = 0, S_RTI = 1, S_SEL_DR = 2, S_CAP_DR = 3, S_SH_DR = 4, S_EX1_DR = 5,
                   S_PAU_DR = 6, S_EX2_DR = 7, S_UPD_DR = 8, S_SEL_IR = 9, S_CAP_IR = 10,
                   S_SH_IR = 11, S_EX1_IR = 12, S_PAU_IR = 13, S_EX2_IR = 14, S_UPD_IR = 15;

    int         nx0 [16];
    int         nx1 [16];
    int         m_state;
    logic [4:0] m_ir;
    logic [4:0] m_irsh;

    task automatic init_model();
        nx0 = '{S_RTI, S_RTI, S_CAP_DR, S_SH_DR, S_SH_DR, S_PAU_DR, S_PAU_DR, S_SH_DR,
                S_RTI, S_CAP_IR, S_SH_IR, S_SH_IR, S_PAU_IR, S_PAU_IR, S_SH_IR, S_RTI};
        nx1 = '{S_TLR, S_SEL_DR, S_SEL_IR, S_EX1_DR, S_EX1_DR, S_UPD_DR, S_EX2_DR, S_UPD_DR,
                S_SEL_DR, S_TLR, S_EX1_IR, S_EX1_IR, S_UPD_IR, S_EX2_IR, S_UPD_IR, S_SEL_DR};
        m_state = S_TLR;
        m_ir    = 5'h01;
        m_irsh  = 5'h01;
    endtask

    task automatic model_update();
        if (trst) begin
            m_state = S_TLR;
            m_ir    = 5'h01;
            m_irsh  = 5'h01;
        end else begin
            if (m_state == S_CAP_IR)      m_irsh = 5'b00001;
            else if (m_state == S_SH_IR)  m_irsh = {tdi, m_irsh[4:1]};
            else if (m_state == S_UPD_IR) m_ir = m_irsh;
            m_state = tms ? nx1[m_state] : nx0[m_state];
            if (m_state == S_TLR) m_ir = 5'h01;
        end
    endtask

    function automatic logic [3:0] exp_sel(input logic [4:0] op);
        case (op)
            5'h01:   return 4'd0;
            5'h03:   return 4'd1;
            5'h08:   return 4'd2;
            5'h09:   return 4'd3;
            5'h0A:   return 4'd4;
            5'h0C:   return 4'd5;
            5'h02:   return 4'd6;
            default: return 4'd7;
        endcase
    endfunction

    task automatic step(input logic p_tms, input logic p_tdi, input logic p_sdo, input logic p_trst);
        @(negedge tck);
        tms  = p_tms;
        tdi  = p_tdi;
        sdo  = p_sdo;
        trst = p_trst;
        @(posedge tck);
        model_update();
        #1;
    endtask

    task automatic go_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // From RTI: full IR scan of op, back to RTI. Returns tdo seen per shift and sel during UPD_IR.
    task automatic ir_scan(input logic [4:0] op, output logic [4:0] seen, output logic [3:0] sel_upd);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            seen[i] = tdo;
            step((i == 4), op[i], 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sel_upd = sel;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (tlr !== 1'b1 || ir !== 5'h01 || sel !== 4'd0)
            $display("FAIL reset_state: tlr=%b ir=%h sel=%0d, want tlr=1 ir=01 sel=0", tlr, ir, sel); else n_pass++;
        go_rti();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (shift_dr !== 1'b1 || tdo !== 1'b1)
            $display("FAIL reset_pre_shdr: shift_dr=%b tdo=%b, want 1 1", shift_dr, tdo); else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (tlr !== 1'b1 || ir !== 5'h01 || sel !== 4'd0)
            $display("FAIL reset_from_shdr: tlr=%b ir=%h sel=%0d, want 1 01 0", tlr, ir, sel); else n_pass++;
        n_checks++; if ({shift_dr, clk_dr, update_dr, tdo, tdo_oe} !== 5'b0)
            $display("FAIL reset_strobes: sh/clk/upd/tdo/oe=%b, want 00000",
                     {shift_dr, clk_dr, update_dr, tdo, tdo_oe}); else n_pass++;
    endtask

    task automatic test_ir_load();
        logic [4:0] seen;
        logic [3:0] su;
        go_rti();
        ir_scan(5'h09, seen, su);
        n_checks++; if (seen !== 5'b00001)
            $display("FAIL ir_load_tdo: seen=%b, want 00001", seen); else n_pass++;
        n_checks++; if (su !== 4'd0)
            $display("FAIL ir_load_sel_at_upd: sel=%0d, want 0", su); else n_pass++;
        n_checks++; if (ir !== 5'h09 || sel !== 4'd3)
            $display("FAIL ir_load_data: ir=%h sel=%0d, want 09 3", ir, sel); else n_pass++;
    endtask

    task automatic test_escape();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++; if (tlr !== (i == 5))
                $display("FAIL escape_tlr_edge%0d: tlr=%b, want %b", i, tlr, (i == 5)); else n_pass++;
        end
        n_checks++; if (ir !== 5'h01)
            $display("FAIL escape_ir: ir=%h, want 01", ir); else n_pass++;
    endtask

    task automatic test_unknown_opcode();
        logic [4:0] ops  [9] = '{5'h15, 5'h0C, 5'h01, 5'h03, 5'h08, 5'h0A, 5'h02, 5'h1F, 5'h09};
        logic [3:0] sels [9] = '{4'd7, 4'd5, 4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd3};
        logic [4:0] seen;
        logic [3:0] su;
        go_rti();
        for (int k = 0; k < 9; k++) begin
            ir_scan(ops[k], seen, su);
            n_checks++; if (sel !== sels[k] || ir !== ops[k] || seen !== 5'b00001)
                $display("FAIL opcode_%h: sel=%0d ir=%h tdo=%b, want sel=%0d ir=%h tdo=00001",
                         ops[k], sel, ir, seen, sels[k], ops[k]); else n_pass++;
        end
    endtask

    // Runs a DR path from SEL_DR using the tms list and tallies strobes per cycle.
    task automatic dr_walk(input logic seq [], output int c_clk, output int c_sh, output int c_upd,
                           output int bad_tdo, output int bad_oe, output int bad_sel, output int bad_pau,
                           output int c_pau);
        logic b;
        c_clk = 0; c_sh = 0; c_upd = 0; bad_tdo = 0; bad_oe = 0; bad_sel = 0; bad_pau = 0; c_pau = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < seq.size(); i++) begin
            b = 1'($urandom_range(0, 1));
            step(seq[i], 1'b0, b, 1'b0);
            c_clk += int'(clk_dr);
            c_sh  += int'(shift_dr);
            c_upd += int'(update_dr);
            if (shift_dr && tdo !== sdo) bad_tdo++;
            if (!shift_dr && tdo !== 1'b0) bad_tdo++;
            if (tdo_oe !== shift_dr) bad_oe++;
            if (sel !== 4'd3) bad_sel++;
            if (m_state == S_PAU_DR) begin
                c_pau++;
                if (shift_dr || clk_dr || update_dr || tdo_oe) bad_pau++;
            end
        end
    endtask

    task automatic test_dr_scan();
        logic seq [];
        int c_clk, c_sh, c_upd, b_tdo, b_oe, b_sel, b_pau, c_pau;
        seq = new[36];
        for (int i = 0; i < 33; i++) seq[i] = 1'b0;
        seq[33] = 1'b1; seq[34] = 1'b1; seq[35] = 1'b0;
        dr_walk(seq, c_clk, c_sh, c_upd, b_tdo, b_oe, b_sel, b_pau, c_pau);
        n_checks++; if (c_clk !== 33 || c_sh !== 32)
            $display("FAIL dr_scan_counts: clk_dr=%0d shift_dr=%0d, want 33 32", c_clk, c_sh); else n_pass++;
        n_checks++; if (c_upd !== 1)
            $display("FAIL dr_scan_update: update_dr cycles=%0d, want 1", c_upd); else n_pass++;
        n_checks++; if (b_tdo !== 0 || b_oe !== 0)
            $display("FAIL dr_scan_tdo: bad tdo=%0d bad oe=%0d, want 0 0", b_tdo, b_oe); else n_pass++;
        n_checks++; if (b_sel !== 0)
            $display("FAIL dr_scan_sel_stable: unstable cycles=%0d, want 0", b_sel); else n_pass++;
    endtask

    task automatic test_pause();
        logic seq [] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int c_clk, c_sh, c_upd, b_tdo, b_oe, b_sel, b_pau, c_pau;
        dr_walk(seq, c_clk, c_sh, c_upd, b_tdo, b_oe, b_sel, b_pau, c_pau);
        n_checks++; if (c_sh !== 6 || c_clk !== 7 || c_upd !== 1)
            $display("FAIL pause_counts: shift=%0d clk=%0d upd=%0d, want 6 7 1", c_sh, c_clk, c_upd); else n_pass++;
        n_checks++; if (c_pau !== 3 || b_pau !== 0)
            $display("FAIL pause_strobes: pause cycles=%0d strobe-high=%0d, want 3 0", c_pau, b_pau); else n_pass++;
    endtask

    task automatic test_ir_abort();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ir !== 5'h01 || tlr !== 1'b1 || sel !== 4'd0)
            $display("FAIL ir_abort: ir=%h tlr=%b sel=%0d, want 01 1 0", ir, tlr, sel); else n_pass++;
        go_rti();
        n_checks++; if (ir !== 5'h01)
            $display("FAIL ir_abort_after: ir=%h, want 01", ir); else n_pass++;
    endtask

    task automatic test_random();
        logic r_tms, r_tdi, r_sdo, r_trst, e_tdo;
        for (int i = 0; i < 4000; i++) begin
            r_tms  = ($urandom_range(0, 99) < 45);
            r_tdi  = 1'($urandom_range(0, 1));
            r_sdo  = 1'($urandom_range(0, 1));
            r_trst = ($urandom_range(0, 99) == 0);
            step(r_tms, r_tdi, r_sdo, r_trst);
            e_tdo = (m_state == S_SH_IR) ? m_irsh[0] : (m_state == S_SH_DR) ? sdo : 1'b0;
            n_checks++; if (ir !== m_ir || sel !== exp_sel(m_ir))
                $display("FAIL rand_ir@%0d: ir=%h sel=%0d, want %h %0d", i, ir, sel, m_ir, exp_sel(m_ir)); else n_pass++;
            n_checks++; if (tlr !== (m_state == S_TLR))
                $display("FAIL rand_tlr@%0d: tlr=%b state=%0d", i, tlr, m_state); else n_pass++;
            n_checks++; if (shift_dr !== (m_state == S_SH_DR) || update_dr !== (m_state == S_UPD_DR) ||
                            clk_dr !== (m_state == S_SH_DR || m_state == S_CAP_DR))
                $display("FAIL rand_strobes@%0d: sh/clk/upd=%b%b%b model state=%0d",
                         i, shift_dr, clk_dr, update_dr, m_state); else n_pass++;
            n_checks++; if (tdo_oe !== (m_state == S_SH_DR || m_state == S_SH_IR) || tdo !== e_tdo)
                $display("FAIL rand_tdo@%0d: tdo=%b oe=%b, want tdo=%b state=%0d",
                         i, tdo, tdo_oe, e_tdo, m_state); else n_pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        init_model();
        test_reset();
        test_ir_load();
        test_escape();
        test_unknown_opcode();
        test_dr_scan();
        test_pause();
        test_ir_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
